// File: rtl/sap_1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// sap_1_controller_sequencer
//
// Controller-sequencer for the SAP-1 datapath. A six-state ring counter
// (T1..T6) walks through the fetch and execute phases. The block decodes the
// 4-bit opcode into the 12-bit control word. State advances on the falling
// edge of Clk, so Con has settled by every rising edge, where the datapath
// registers load.
//
// Ports
//   Clk    in   1   system clock (sequencer updates on the falling edge)
//   Clr    in   1   synchronous active-high reset, sampled on the falling edge
//   Instr  in   4   opcode from the upper nibble of the instruction register
//   Con    out 12   {Cp, Ep, LMbar, CEbar, LIbar, EIbar, LAbar, Ea, Su, Eu,
//                    LBbar, LObar}, bit 11 = Cp
//   T      out  6   one-hot ring state, T[0] = T1 .. T[5] = T6, zero in HALT
//   Hlt    out  1   high only while halted
// -----------------------------------------------------------------------------
module sap_1_controller_sequencer (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [3:0]  Instr,
    output logic [11:0] Con,
    output logic [5:0]  T,
    output logic        Hlt
);

    // One-hot state: bits 5:0 are the ring T1..T6, bit 6 is HALT.
    localparam logic [6:0] S_T1   = 7'b000_0001;
    localparam logic [6:0] S_T2   = 7'b000_0010;
    localparam logic [6:0] S_T3   = 7'b000_0100;
    localparam logic [6:0] S_T4   = 7'b000_1000;
    localparam logic [6:0] S_T5   = 7'b001_0000;
    localparam logic [6:0] S_T6   = 7'b010_0000;
    localparam logic [6:0] S_HALT = 7'b100_0000;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control words. NOP keeps every active-low strobe high and every
    // active-high control low, so no register loads and no bus driver is on.
    localparam logic [11:0] CON_NOP     = 12'h3E3;
    localparam logic [11:0] CON_FETCH1  = 12'h5E3;  // Ep, LMbar
    localparam logic [11:0] CON_FETCH2  = 12'hBE3;  // Cp
    localparam logic [11:0] CON_FETCH3  = 12'h263;  // CEbar, LIbar
    localparam logic [11:0] CON_IR_MAR  = 12'h1A3;  // EIbar, LMbar
    localparam logic [11:0] CON_RAM_A   = 12'h2C3;  // CEbar, LAbar
    localparam logic [11:0] CON_RAM_B   = 12'h2E1;  // CEbar, LBbar
    localparam logic [11:0] CON_ADD_A   = 12'h3C7;  // Eu, LAbar
    localparam logic [11:0] CON_SUB_A   = 12'h3CF;  // Su, Eu, LAbar
    localparam logic [11:0] CON_A_OUT   = 12'h3F2;  // Ea, LObar

    logic [6:0] state_q;
    logic [6:0] state_d;

    // State register: falling-edge update so Con is settled for the
    // datapath's rising-edge loads. Clr overrides every transition.
    always_ff @(negedge Clk) begin
        if (Clr) begin
            state_q <= S_T1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Any encoding that is not one-hot falls back to T1.
    always_comb begin
        state_d = S_T1;
        case (state_q)
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = (Instr == OP_HLT) ? S_HALT : S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = S_T1;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_T1;
        endcase
    end

    // Output logic. Instr only matters in T4..T6, so IR glitches during the
    // fetch phase cannot reach Con.
    always_comb begin
        Con = CON_NOP;
        T   = state_q[5:0];
        Hlt = 1'b0;
        case (state_q)
            S_T1: Con = CON_FETCH1;
            S_T2: Con = CON_FETCH2;
            S_T3: Con = CON_FETCH3;
            S_T4: begin
                case (Instr)
                    OP_LDA, OP_ADD, OP_SUB: Con = CON_IR_MAR;
                    OP_OUT:                 Con = CON_A_OUT;
                    default:                Con = CON_NOP;
                endcase
            end
            S_T5: begin
                case (Instr)
                    OP_LDA:         Con = CON_RAM_A;
                    OP_ADD, OP_SUB: Con = CON_RAM_B;
                    default:        Con = CON_NOP;
                endcase
            end
            S_T6: begin
                case (Instr)
                    OP_ADD:  Con = CON_ADD_A;
                    OP_SUB:  Con = CON_SUB_A;
                    default: Con = CON_NOP;
                endcase
            end
            S_HALT: begin
                T   = 6'b00_0000;
                Hlt = 1'b1;
            end
            default: begin
                // Unreachable illegal encoding: issue NOP until the next
                // falling edge restores T1.
                Con = CON_NOP;
            end
        endcase
    end

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
module tb_sap_1_controller_sequencer;

    logic        Clk = 1'b1;
    logic        Clr = 1'b1;
    logic [3:0]  Instr = 4'b0000;
    logic [11:0] Con;
    logic [5:0]  T;
    logic        Hlt;

    int passed = 0;
    int total  = 0;

    logic watch    = 1'b0;
    logic seen_bad = 1'b0;

    sap_1_controller_sequencer dut (
        .Clk   (Clk),
        .Clr   (Clr),
        .Instr (Instr),
        .Con   (Con),
        .T     (T),
        .Hlt   (Hlt)
    );

    always #5 Clk = ~Clk;

    // Any ADD T6 word issued on a rising edge while watching is an error.
    always @(posedge Clk) begin
        if (watch && Con === 12'h3C7) seen_bad <= 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        clr;
        logic [3:0]  instr;
        logic [5:0]  t;
        logic [11:0] con;
        logic        hlt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Apply inputs, let one falling edge take effect, then settle.
    task automatic step(input logic clr, input logic [3:0] ins);
        Clr   = clr;
        Instr = ins;
        @(negedge Clk);
        #2;
    endtask

    task automatic expect_out(input string nm, input logic [5:0] t,
                              input logic [11:0] con, input logic hlt);
        chk({nm, ".T"},   {6'b0, T},    {6'b0, t});
        chk({nm, ".Con"}, Con,          con);
        chk({nm, ".Hlt"}, {11'b0, Hlt}, {11'b0, hlt});
    endtask

    initial begin
        // Reset, then fetch with glitching Instr in T1..T3 ignored
        vecs.push_back('{1'b1, 4'h0, T1, 12'h5E3, 1'b0});
        vecs.push_back('{1'b1, 4'h0, T1, 12'h5E3, 1'b0});
        vecs.push_back('{1'b0, 4'h0, T2, 12'hBE3, 1'b0});
        vecs.push_back('{1'b0, 4'hF, T3, 12'h263, 1'b0});
        // LDA
        vecs.push_back('{1'b0, 4'h0, T4, 12'h1A3, 1'b0});
        vecs.push_back('{1'b0, 4'h0, T5, 12'h2C3, 1'b0});
        vecs.push_back('{1'b0, 4'h0, T6, 12'h3E3, 1'b0});
        vecs.push_back('{1'b0, 4'hF, T1, 12'h5E3, 1'b0});
        vecs.push_back('{1'b0, 4'h3, T2, 12'hBE3, 1'b0});
        vecs.push_back('{1'b0, 4'h1, T3, 12'h263, 1'b0});
        // ADD
        vecs.push_back('{1'b0, 4'h1, T4, 12'h1A3, 1'b0});
        vecs.push_back('{1'b0, 4'h1, T5, 12'h2E1, 1'b0});
        vecs.push_back('{1'b0, 4'h1, T6, 12'h3C7, 1'b0});
        vecs.push_back('{1'b0, 4'h2, T1, 12'h5E3, 1'b0});
        vecs.push_back('{1'b0, 4'h2, T2, 12'hBE3, 1'b0});
        vecs.push_back('{1'b0, 4'h2, T3, 12'h263, 1'b0});
        // SUB
        vecs.push_back('{1'b0, 4'h2, T4, 12'h1A3, 1'b0});
        vecs.push_back('{1'b0, 4'h2, T5, 12'h2E1, 1'b0});
        vecs.push_back('{1'b0, 4'h2, T6, 12'h3CF, 1'b0});
        vecs.push_back('{1'b0, 4'hE, T1, 12'h5E3, 1'b0});
        vecs.push_back('{1'b0, 4'hE, T2, 12'hBE3, 1'b0});
        vecs.push_back('{1'b0, 4'hE, T3, 12'h263, 1'b0});
        // OUT
        vecs.push_back('{1'b0, 4'hE, T4, 12'h3F2, 1'b0});
        vecs.push_back('{1'b0, 4'hE, T5, 12'h3E3, 1'b0});
        vecs.push_back('{1'b0, 4'hE, T6, 12'h3E3, 1'b0});
        vecs.push_back('{1'b0, 4'h7, T1, 12'h5E3, 1'b0});
        vecs.push_back('{1'b0, 4'h7, T2, 12'hBE3, 1'b0});
        vecs.push_back('{1'b0, 4'h7, T3, 12'h263, 1'b0});
        // Undefined opcode 0111, ring wraps to T1
        vecs.push_back('{1'b0, 4'h7, T4, 12'h3E3, 1'b0});
        vecs.push_back('{1'b0, 4'h7, T5, 12'h3E3, 1'b0});
        vecs.push_back('{1'b0, 4'h7, T6, 12'h3E3, 1'b0});
        vecs.push_back('{1'b0, 4'h7, T1, 12'h5E3, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].instr);
            expect_out($sformatf("vec%0d", i), vecs[i].t, vecs[i].con, vecs[i].hlt);
        end

        // HLT: halt after T4, stay halted whatever Instr does, leave on Clr
        step(1'b0, 4'hF); expect_out("hlt_t2", T2, 12'hBE3, 1'b0);
        step(1'b0, 4'hF); expect_out("hlt_t3", T3, 12'h263, 1'b0);
        step(1'b0, 4'hF); expect_out("hlt_t4", T4, 12'h3E3, 1'b0);
        for (int k = 0; k < 12; k++) begin
            logic [3:0] ins;
            ins = (k == 0) ? 4'hF : 4'(k);
            step(1'b0, ins);
            expect_out($sformatf("halt%0d", k), 6'b000000, 12'h3E3, 1'b1);
        end
        step(1'b1, 4'h0); expect_out("halt_clr", T1, 12'h5E3, 1'b0);

        // Mid-instruction reset at the edge ending T5 of an ADD
        step(1'b0, 4'h1); expect_out("mid_t2", T2, 12'hBE3, 1'b0);
        step(1'b0, 4'h1); expect_out("mid_t3", T3, 12'h263, 1'b0);
        step(1'b0, 4'h1); expect_out("mid_t4", T4, 12'h1A3, 1'b0);
        step(1'b0, 4'h1); expect_out("mid_t5", T5, 12'h2E1, 1'b0);
        watch = 1'b1;
        step(1'b1, 4'h1); expect_out("mid_clr", T1, 12'h5E3, 1'b0);
        Instr = 4'h0;
        #1;
        step(1'b0, 4'h0); expect_out("mid_n2", T2, 12'hBE3, 1'b0);
        step(1'b0, 4'h0); expect_out("mid_n3", T3, 12'h263, 1'b0);
        step(1'b0, 4'h0); expect_out("mid_n4", T4, 12'h1A3, 1'b0);
        step(1'b0, 4'h0); expect_out("mid_n5", T5, 12'h2C3, 1'b0);
        step(1'b0, 4'h0); expect_out("mid_n6", T6, 12'h3E3, 1'b0);
        step(1'b0, 4'h0); expect_out("mid_n1", T1, 12'h5E3, 1'b0);
        @(posedge Clk);
        #1;
        watch = 1'b0;
        chk("no_add_t6_word", {11'b0, seen_bad}, 12'h000);

        // Clr beats the T4 -> HALT transition
        step(1'b0, 4'hF); expect_out("pri_t2", T2, 12'hBE3, 1'b0);
        step(1'b0, 4'hF); expect_out("pri_t3", T3, 12'h263, 1'b0);
        step(1'b0, 4'hF); expect_out("pri_t4", T4, 12'h3E3, 1'b0);
        step(1'b1, 4'hF); expect_out("pri_clr", T1, 12'h5E3, 1'b0);
        step(1'b0, 4'hF); expect_out("pri_t2b", T2, 12'hBE3, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
